// File: rtl/load_store_unit.sv
// load_store_unit: bridges the MEM stage and a byte-addressed data memory.
// Takes one load/store per req handshake, drives the memory port, and returns
// an extended load result or store completion on a resp handshake. Loads the
// memory cannot serve in one access are assembled from single-byte reads.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses return an
// error instead of being split (loads) or written natively (stores).
module load_store_unit #(
  parameter int XLEN     = 32,
  parameter int MEM_SIZE = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wr_en,
  output logic [1:0]      mem_load_type,
  output logic            mem_read,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_SPLIT  = 2'b10,
    ST_RESP   = 2'b11
  } state_t;

  localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_SIZE);

  // Access size in bytes from funct3[1:0]; 11 is illegal and caught elsewhere.
  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  // Index of the last byte lane of a split access.
  function automatic logic [1:0] last_lane(input logic [1:0] f);
    case (f)
      2'b00:   last_lane = 2'd0;
      2'b01:   last_lane = 2'd1;
      default: last_lane = 2'd3;
    endcase
  endfunction

  // Byte write enables for SB/SH/SW.
  function automatic logic [3:0] wr_mask(input logic [1:0] f);
    case (f)
      2'b00:   wr_mask = 4'b0001;
      2'b01:   wr_mask = 4'b0011;
      default: wr_mask = 4'b1111;
    endcase
  endfunction

  // Final load extension: signed forms sign-extend, unsigned forms zero-extend.
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'b000:  extend_load = {{(XLEN-8){d[7]}}, d[7:0]};
      3'b001:  extend_load = {{(XLEN-16){d[15]}}, d[15:0]};
      3'b100:  extend_load = {{(XLEN-8){1'b0}}, d[7:0]};
      3'b101:  extend_load = {{(XLEN-16){1'b0}}, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

  state_t          state_r, state_next_s;
  logic            op_we_r;
  logic [2:0]      op_funct3_r;
  logic [XLEN-1:0] op_addr_r, op_wdata_r, bytes_r, resp_rdata_r, assembled_s;
  logic [1:0]      cnt_r;
  logic            resp_err_r;

  logic [2:0]      req_size_s;
  logic [XLEN:0]   req_end_s;
  logic            illegal_s, range_err_s, misalign_s, req_err_s, split_s;

  assign req_ready  = (state_r == ST_IDLE);
  assign resp_valid = (state_r == ST_RESP);
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Classify the incoming request: legality, range, alignment, split need.
  always_comb begin
    req_size_s  = size_of(req_funct3[1:0]);
    req_end_s   = {1'b0, req_addr} + {{(XLEN-2){1'b0}}, req_size_s};
    range_err_s = (req_end_s > MEM_LIMIT);
    illegal_s   = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & (req_we | req_funct3[1]));
    case (req_funct3[1:0])
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = req_addr[0];
      default: misalign_s = (req_addr[1:0] != 2'b00);
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    req_err_s = illegal_s | range_err_s | misalign_s;
    split_s   = 1'b0;
`else
    req_err_s = illegal_s | range_err_s;
    split_s   = ~req_we & misalign_s;
`endif
  end

  // Insert the byte returned this cycle into its lane of the split buffer.
  always_comb begin
    assembled_s = bytes_r;
    assembled_s[{cnt_r, 3'b000} +: 8] = mem_rdata[7:0];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic and memory port drive; memory port idles at zero.
  always_comb begin
    state_next_s  = state_r;
    mem_addr      = {XLEN{1'b0}};
    mem_wdata     = {XLEN{1'b0}};
    mem_wr_en     = 4'b0000;
    mem_load_type = 2'b00;
    mem_read      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err_s)    state_next_s = ST_RESP;
          else if (split_s) state_next_s = ST_SPLIT;
          else              state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        mem_addr     = op_addr_r;
        state_next_s = ST_RESP;
        if (op_we_r) begin
          mem_wdata = op_wdata_r;
          mem_wr_en = wr_mask(op_funct3_r[1:0]);
        end else begin
          mem_read      = 1'b1;
          mem_load_type = op_funct3_r[1:0];
        end
      end
      ST_SPLIT: begin
        mem_read = 1'b1;
        mem_addr = op_addr_r + {{(XLEN-2){1'b0}}, cnt_r};
        if (cnt_r == last_lane(op_funct3_r[1:0])) state_next_s = ST_RESP;
        else                                      state_next_s = ST_SPLIT;
      end
      ST_RESP: begin
        if (resp_ready) state_next_s = ST_IDLE;
        else            state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Request capture, byte assembly and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_we_r      <= 1'b0;
      op_funct3_r  <= 3'b000;
      op_addr_r    <= {XLEN{1'b0}};
      op_wdata_r   <= {XLEN{1'b0}};
      bytes_r      <= {XLEN{1'b0}};
      cnt_r        <= 2'd0;
      resp_rdata_r <= {XLEN{1'b0}};
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_we_r      <= req_we;
            op_funct3_r  <= req_funct3;
            op_addr_r    <= req_addr;
            op_wdata_r   <= req_wdata;
            bytes_r      <= {XLEN{1'b0}};
            cnt_r        <= 2'd0;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_err_r   <= req_err_s;
          end
        end
        ST_ACCESS: begin
          if (op_we_r) resp_rdata_r <= {XLEN{1'b0}};
          else         resp_rdata_r <= extend_load(op_funct3_r, mem_rdata);
        end
        ST_SPLIT: begin
          bytes_r <= assembled_s;
          cnt_r   <= cnt_r + 2'd1;
          if (cnt_r == last_lane(op_funct3_r[1:0]))
            resp_rdata_r <= extend_load(op_funct3_r, assembled_s);
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_rdata_r <= {XLEN{1'b0}};
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          cnt_r <= 2'd0;
        end
      endcase
    end
  end

endmodule
